// File: rtl/vc_wrr_arbiter_if.sv
// vc_wrr_arbiter_if: scheduler-side bundle between VC FIFOs, control and the D0/D1 demux.
// With VC_ARB_STATS_EN defined, also carries the grant counters and their clear.
interface vc_wrr_arbiter_if #(
  parameter int DATA_WIDTH = 6,
  parameter int WEIGHT_WIDTH = 4
);
  logic enable;
  logic [WEIGHT_WIDTH-1:0] weight_vc0, weight_vc1;
  logic empty_vc0, empty_vc1, pause_d0, pause_d1;
  logic [DATA_WIDTH-1:0] data_vc0, data_vc1;
  logic pop_vc0, pop_vc1;
  logic [DATA_WIDTH-1:0] data_out;
  logic valid_out;
  logic [1:0] state_out;
`ifdef VC_ARB_STATS_EN
  logic stats_clr;
  logic [15:0] grant_cnt_vc0, grant_cnt_vc1;
  modport slave (
    input enable, weight_vc0, weight_vc1, empty_vc0, empty_vc1, pause_d0, pause_d1,
          data_vc0, data_vc1, stats_clr,
    output pop_vc0, pop_vc1, data_out, valid_out, state_out, grant_cnt_vc0, grant_cnt_vc1
  );
  modport master (
    output enable, weight_vc0, weight_vc1, empty_vc0, empty_vc1, pause_d0, pause_d1,
           data_vc0, data_vc1, stats_clr,
    input pop_vc0, pop_vc1, data_out, valid_out, state_out, grant_cnt_vc0, grant_cnt_vc1
  );
`else
  modport slave (
    input enable, weight_vc0, weight_vc1, empty_vc0, empty_vc1, pause_d0, pause_d1,
          data_vc0, data_vc1,
    output pop_vc0, pop_vc1, data_out, valid_out, state_out
  );
  modport master (
    output enable, weight_vc0, weight_vc1, empty_vc0, empty_vc1, pause_d0, pause_d1,
           data_vc0, data_vc1,
    input pop_vc0, pop_vc1, data_out, valid_out, state_out
  );
`endif
endinterface

// File: rtl/vc_wrr_arbiter.sv
// vc_wrr_arbiter: work-conserving weighted round-robin pops of VC0/VC1 with a 2-cycle registered data path.
// Defining VC_ARB_STATS_EN adds saturating per-VC grant counters with stats_clr.
module vc_wrr_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int WEIGHT_WIDTH = 4
) (
  input logic clk,
  input logic reset_L,
  vc_wrr_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE_VC0 = 2'd1, SERVE_VC1 = 2'd2} state_t;
  state_t state;
  logic [WEIGHT_WIDTH-1:0] credit, w0, w1, w_me, w_ot;
  logic [DATA_WIDTH-1:0] sel_data;
  logic last, pause_q, sel_v, sel_vc, cur, e_me, e_ot, take0, pop0, pop1;
  assign w0 = bus.weight_vc0 == '0 ? WEIGHT_WIDTH'(1) : bus.weight_vc0;
  assign w1 = bus.weight_vc1 == '0 ? WEIGHT_WIDTH'(1) : bus.weight_vc1;
  assign cur = state == SERVE_VC1;
  assign e_me = cur ? bus.empty_vc1 : bus.empty_vc0;
  assign e_ot = cur ? bus.empty_vc0 : bus.empty_vc1;
  assign w_me = cur ? w1 : w0;
  assign w_ot = cur ? w0 : w1;
  // last=1 means VC1 was served last, so VC0 is preferred
  assign take0 = last ? !bus.empty_vc0 : bus.empty_vc1;
  assign pop0 = bus.enable && state == SERVE_VC0 && !bus.empty_vc0 && !pause_q;
  assign pop1 = bus.enable && state == SERVE_VC1 && !bus.empty_vc1 && !pause_q;
  assign sel_data = sel_vc ? bus.data_vc1 : bus.data_vc0;
  assign bus.pop_vc0 = pop0;
  assign bus.pop_vc1 = pop1;
  assign bus.state_out = state;
  always_ff @(posedge clk) begin
    if (reset_L) begin
      state <= IDLE;
      credit <= '0;
      last <= 1'b1;
      pause_q <= 1'b0;
      sel_v <= 1'b0;
      sel_vc <= 1'b0;
      bus.data_out <= '0;
      bus.valid_out <= 1'b0;
    end else begin
      pause_q <= bus.pause_d0 | bus.pause_d1;
      sel_v <= pop0 | pop1;
      sel_vc <= pop1;
      bus.valid_out <= sel_v;
      if (sel_v) bus.data_out <= sel_data;
      if (!pause_q) begin
        if (state == IDLE) begin
          if (bus.enable && !(bus.empty_vc0 && bus.empty_vc1)) begin
            state <= take0 ? SERVE_VC0 : SERVE_VC1;
            credit <= take0 ? w0 : w1;
          end
        end else if (!bus.enable || (e_me && e_ot)) begin
          state <= IDLE;
          last <= cur;
        end else if (e_me || (credit == WEIGHT_WIDTH'(1) && !e_ot)) begin
          // own queue dry or turn used up with the other VC waiting: hand over, drop leftover credit
          state <= cur ? SERVE_VC0 : SERVE_VC1;
          credit <= w_ot;
          last <= cur;
        end else begin
          credit <= credit == WEIGHT_WIDTH'(1) ? w_me : credit - WEIGHT_WIDTH'(1);
        end
      end
    end
  end
`ifdef VC_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset_L || bus.stats_clr) begin
      bus.grant_cnt_vc0 <= '0;
      bus.grant_cnt_vc1 <= '0;
    end else begin
      if (pop0 && bus.grant_cnt_vc0 != 16'hFFFF) bus.grant_cnt_vc0 <= bus.grant_cnt_vc0 + 16'd1;
      if (pop1 && bus.grant_cnt_vc1 != 16'hFFFF) bus.grant_cnt_vc1 <= bus.grant_cnt_vc1 + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// tb_vc_wrr_arbiter: scoreboard bench with VC FIFO models; pop order and output words checked against predictions.
module tb_vc_wrr_arbiter;
  typedef struct {int due; logic [5:0] d;} exp_t;
  logic clk, reset_L;
  vc_wrr_arbiter_if #(.DATA_WIDTH(6), .WEIGHT_WIDTH(4)) bus();
  vc_wrr_arbiter #(.DATA_WIDTH(6), .WEIGHT_WIDTH(4)) dut(.clk(clk), .reset_L(reset_L), .bus(bus.slave));
  logic [5:0] mem0 [256];
  logic [5:0] mem1 [256];
  logic [7:0] rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0;
  bit inf0 = 0, mon = 1, s_p0 = 0, s_p1 = 0, pz = 0;
  int cyc = 0, n0 = 0, n1 = 0, vcnt_p = 0, n_chk = 0, n_pass = 0;
  exp_t sb[$];
  bit exp_src[$];
  initial clk = 0;
  always #5 clk = ~clk;
  assign bus.empty_vc0 = !inf0 && rd0 == wr0;
  assign bus.empty_vc1 = rd1 == wr1;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pz <= bus.pause_d0 | bus.pause_d1;
    if (s_p0) begin
      bus.data_vc0 <= mem0[rd0];
      rd0 <= rd0 + 8'd1;
    end
    if (s_p1) begin
      bus.data_vc1 <= mem1[rd1];
      rd1 <= rd1 + 8'd1;
    end
  end
  always @(negedge clk) begin
    logic [5:0] w;
    s_p0 = bus.pop_vc0;
    s_p1 = bus.pop_vc1;
    if (mon) begin
      if (pz) check("pop_in_pause", {31'd0, bus.pop_vc0 | bus.pop_vc1}, 0);
      if (bus.pop_vc0 || bus.pop_vc1) begin
        check("both_pops", {31'd0, bus.pop_vc0 & bus.pop_vc1}, 0);
        check("pop_expected", {31'd0, exp_src.size() != 0}, 1);
        if (exp_src.size() != 0) check("pop_src", {31'd0, bus.pop_vc1}, {31'd0, exp_src.pop_front()});
        check("state_serve", {30'd0, bus.state_out}, bus.pop_vc1 ? 2 : 1);
        w = bus.pop_vc1 ? 6'(32 + n1) : 6'(n0);
        if (bus.pop_vc1) n1++;
        else n0++;
        sb.push_back('{cyc + 2, w});
      end
      if (bus.valid_out) begin
        check("valid_expected", {31'd0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("latency", cyc, e.due);
          check("data", {26'd0, bus.data_out}, {26'd0, e.d});
        end
        if (pz) vcnt_p++;
      end
    end
  end
  task automatic load(int a, int b);
    for (int i = 0; i < a; i++) begin
      mem0[wr0] = 6'(i);
      wr0 = wr0 + 8'd1;
    end
    for (int i = 0; i < b; i++) begin
      mem1[wr1] = 6'(32 + i);
      wr1 = wr1 + 8'd1;
    end
  endtask
  task automatic rst();
    inf0 = 0;
    bus.enable = 0;
    bus.pause_d0 = 0;
    bus.pause_d1 = 0;
`ifdef VC_ARB_STATS_EN
    bus.stats_clr = 0;
`endif
    reset_L = 1;
    step(2);
    wr0 = rd0;
    wr1 = rd1;
    reset_L = 0;
    sb.delete();
    exp_src.delete();
    n0 = 0;
    n1 = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && (exp_src.size() != 0 || sb.size() != 0); i++) step(1);
    check("drain_pops", exp_src.size(), 0);
    check("drain_words", sb.size(), 0);
  endtask
  initial begin
    bus.weight_vc0 = 1;
    bus.weight_vc1 = 1;
    rst();
    @(negedge clk);
    check("rst_state", {30'd0, bus.state_out}, 0);
    check("rst_valid", {31'd0, bus.valid_out}, 0);
    check("rst_data", {26'd0, bus.data_out}, 0);
    check("rst_pops", {30'd0, bus.pop_vc0, bus.pop_vc1}, 0);
    // VC0 alone, weight 2: four back-to-back pops
    step(1);
    bus.weight_vc0 = 2;
    bus.weight_vc1 = 1;
    load(4, 0);
    exp_src = '{0, 0, 0, 0};
    bus.enable = 1;
    drain();
    // weights 3/1 with both loaded, then VC1 finishes alone
    rst();
    bus.weight_vc0 = 3;
    bus.weight_vc1 = 1;
    load(6, 6);
    exp_src = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    bus.enable = 1;
    drain();
    // zero weights behave as one: strict alternation
    rst();
    bus.weight_vc0 = 0;
    bus.weight_vc1 = 0;
    load(3, 3);
    exp_src = '{0, 1, 0, 1, 0, 1};
    bus.enable = 1;
    drain();
    // pause mid-turn keeps remaining VC0 credit
    rst();
    bus.weight_vc0 = 3;
    bus.weight_vc1 = 2;
    load(4, 4);
    exp_src = '{0, 0, 0, 1, 1, 0, 1, 1};
    bus.enable = 1;
    step(2);
    bus.pause_d1 = 1;
    vcnt_p = 0;
    step(3);
    bus.pause_d1 = 0;
    drain();
    check("pause_inflight", vcnt_p, 2);
    // enable dropped mid-turn, re-enable serves VC1 first
    rst();
    bus.weight_vc0 = 4;
    bus.weight_vc1 = 4;
    load(8, 4);
    exp_src = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    bus.enable = 1;
    step(3);
    bus.enable = 0;
    @(negedge clk);
    check("pop_off", {30'd0, bus.pop_vc0, bus.pop_vc1}, 0);
    step(1);
    @(negedge clk);
    check("idle_after_disable", {30'd0, bus.state_out}, 0);
    step(1);
    bus.enable = 1;
    drain();
    // reset mid-stream drops the word in flight
    rst();
    bus.weight_vc0 = 2;
    bus.weight_vc1 = 2;
    load(4, 0);
    exp_src = '{0, 0, 0, 0};
    bus.enable = 1;
    step(2);
    reset_L = 1;
    step(1);
    @(negedge clk);
    check("rst_mid_valid", {31'd0, bus.valid_out}, 0);
    check("rst_mid_state", {30'd0, bus.state_out}, 0);
    rst();
`ifdef VC_ARB_STATS_EN
    mon = 0;
    inf0 = 1;
    bus.weight_vc0 = 1;
    bus.weight_vc1 = 1;
    bus.enable = 1;
    step(11);
    check("gcnt_10", {16'd0, bus.grant_cnt_vc0}, 10);
    step(70000);
    check("gcnt_sat", {16'd0, bus.grant_cnt_vc0}, 32'h0000FFFF);
    check("gcnt_vc1", {16'd0, bus.grant_cnt_vc1}, 0);
    bus.stats_clr = 1;
    step(1);
    check("gcnt_clr", {16'd0, bus.grant_cnt_vc0}, 0);
    bus.stats_clr = 0;
    step(1);
    check("gcnt_after_clr", {16'd0, bus.grant_cnt_vc0}, 1);
    rst();
    mon = 1;
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
